// File: rtl/myio_axil_arbiter.sv
// Round-robin arbiter that lets N_REQ local requesters share one AXI4-Lite master port.
// Exactly one AXI transaction is outstanding at a time, and each command gets a single completion pulse.
module myio_axil_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_DONE
  } state_t;

  state_t                r_state, w_nextState;
  logic [GW-1:0]         r_lastGrant, r_grant, w_grantIdx;
  logic                  w_anyGrant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awDone, r_wDone;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic [1:0]            r_rspResp;
  logic                  w_awHs, w_wHs;
  logic                  w_unused;

  assign w_awHs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_wHs  = M_AXI_WVALID & M_AXI_WREADY;

  // Rotating search starting just above the previous winner.
  always_comb begin
    int            idx;
    logic [GW-1:0] w_idx;
    w_anyGrant = 1'b0;
    w_grantIdx = '0;
    idx        = 0;
    w_idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(r_lastGrant) + k) % N_REQ;
      w_idx = GW'(idx);
      if (!w_anyGrant && req_valid[w_idx]) begin
        w_anyGrant = 1'b1;
        w_grantIdx = w_idx;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_anyGrant) w_nextState = req_we[w_grantIdx] ? S_WR : S_RD;
      S_WR:      if ((r_awDone | w_awHs) && (r_wDone | w_wHs)) w_nextState = S_WR_RESP;
      S_WR_RESP: if (M_AXI_BVALID) w_nextState = S_DONE;
      S_RD:      if (M_AXI_ARREADY) w_nextState = S_RD_RESP;
      S_RD_RESP: if (M_AXI_RVALID) w_nextState = S_DONE;
      S_DONE:    w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      S_IDLE:    if (w_anyGrant && !ARESET) req_ready[w_grantIdx] = 1'b1;
      S_WR: begin
        M_AXI_AWVALID = ~r_awDone;
        M_AXI_WVALID  = ~r_wDone;
      end
      S_WR_RESP: M_AXI_BREADY  = 1'b1;
      S_RD:      M_AXI_ARVALID = 1'b1;
      S_RD_RESP: M_AXI_RREADY  = 1'b1;
      S_DONE:    rsp_valid[r_grant] = 1'b1;
      default:   ;
    endcase
  end

  // The command payload is frozen at grant, so AXI payloads never move while valid is high.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_lastGrant <= GW'(N_REQ - 1);
      r_grant     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awDone    <= 1'b0;
      r_wDone     <= 1'b0;
      r_rspRdata  <= '0;
      r_rspResp   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyGrant) begin
            r_grant     <= w_grantIdx;
            r_lastGrant <= w_grantIdx;
            r_addr      <= req_addr[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata     <= req_wdata[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];
            r_awDone    <= 1'b0;
            r_wDone     <= 1'b0;
          end
        end
        S_WR: begin
          if (w_awHs) r_awDone <= 1'b1;
          if (w_wHs)  r_wDone  <= 1'b1;
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_rspRdata <= '0;
            r_rspResp  <= M_AXI_BRESP;
          end
        end
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            r_rspRdata <= M_AXI_RDATA;
            r_rspResp  <= M_AXI_RRESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign M_AXI_AWADDR = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_ARADDR = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = '1;
  assign rsp_rdata    = r_rspRdata;
  assign rsp_resp     = r_rspResp;
  assign w_unused     = &{1'b0, r_addr[1:0]};

endmodule
